// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_arbiter_pkg
// Brief    : Shared memory-system definitions: default block address and
//            line widths, and the arbiter state encoding. Imported by the
//            caches and the arbiter so every block agrees on the sizes.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

   localparam int c_addr_w = 28;    // main-memory block address width
   localparam int c_line_w = 128;   // cache line width

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2,
      RESP    = 2'd3
   } arb_state_t;

   // True while a memory access is outstanding on behalf of either cache.
   function automatic logic is_serve(input arb_state_t s);
      return (s == SERVE_I) || (s == SERVE_D);
   endfunction

endpackage
`default_nettype wire

// File: rtl/arb_grant_select.sv
`default_nettype none
// ============================================================================
// Module   : arb_grant_select
// Brief    : Combinational winner selection between the instruction and
//            data caches. Fixed data-side priority by default.
// Config   : RR_ARB_EN - when defined, a simultaneous request goes to the
//            side that was not served last (round-robin).
// Revision : 1.0 - initial release
// ============================================================================
module arb_grant_select (
   input  logic i_req_icache,
   input  logic i_req_dcache,
`ifdef RR_ARB_EN
   input  logic i_last_was_d,
`endif
   output logic o_grant_valid,
   output logic o_grant_dcache
);

   // Pick the winner; only a true collision consults the priority rule.
   always_comb begin
      o_grant_valid  = i_req_icache | i_req_dcache;
      o_grant_dcache = i_req_dcache;
      if (i_req_icache && i_req_dcache) begin
`ifdef RR_ARB_EN
         o_grant_dcache = ~i_last_was_d;
`else
         o_grant_dcache = 1'b1;
`endif
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Arbitrates the instruction and data caches onto one main-memory
//            port. A granted access is latched and held stable until memory
//            completes, then a single RESP cycle releases the requester.
// Config   : RR_ARB_EN - round-robin arbitration on simultaneous requests
//            (default: fixed data-side priority, no pointer state).
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = c_addr_w,
   parameter int LINE_W = c_line_w
) (
   input  logic              clock,
   input  logic              reset,
   // instruction cache
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic [LINE_W-1:0] i_readdata,
   output logic              i_busywait,
   // data cache
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_writedata,
   output logic [LINE_W-1:0] d_readdata,
   output logic              d_busywait,
   // main memory
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [LINE_W-1:0] mem_writedata,
   input  logic [LINE_W-1:0] mem_readdata,
   input  logic              mem_busywait
);

   arb_state_t        state_q, state_d;
   logic              gnt_d_q, gnt_d_d;     // 1: current/last grant is the data side
   logic              write_q, write_d;     // latched operation
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
   logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
`ifdef RR_ARB_EN
   logic              last_d_q, last_d_d;   // 0: instruction side served last
`endif

   logic w_i_req;
   logic w_d_req;
   logic w_owner_req;
   logic w_grant_valid;
   logic w_grant_d;

   assign w_i_req     = i_read;
   assign w_d_req     = d_read | d_write;
   assign w_owner_req = gnt_d_q ? w_d_req : w_i_req;

   arb_grant_select u_grant_select (
      .i_req_icache   (w_i_req),
      .i_req_dcache   (w_d_req),
`ifdef RR_ARB_EN
      .i_last_was_d   (last_d_q),
`endif
      .o_grant_valid  (w_grant_valid),
      .o_grant_dcache (w_grant_d)
   );

   // Next-state and datapath capture: latch the request at grant, hold it
   // during the access, capture read data only if the owner is still waiting.
   always_comb begin
      state_d   = state_q;
      gnt_d_d   = gnt_d_q;
      write_d   = write_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
`ifdef RR_ARB_EN
      last_d_d  = last_d_q;
`endif
      case (state_q)
         IDLE: begin
            if (w_grant_valid) begin
               gnt_d_d = w_grant_d;
               if (w_grant_d) begin
                  state_d = SERVE_D;
                  write_d = d_write;          // read+write together counts as a write
                  addr_d  = d_address;
                  wdata_d = d_writedata;
               end else begin
                  state_d = SERVE_I;
                  write_d = 1'b0;
                  addr_d  = i_address;
                  wdata_d = '0;
               end
`ifdef RR_ARB_EN
               last_d_d = w_grant_d;
`endif
            end
         end
         SERVE_I, SERVE_D: begin
            if (!mem_busywait) begin
               if (w_owner_req) begin
                  state_d = RESP;
                  if (!write_q) begin
                     if (gnt_d_q) d_rdata_d = mem_readdata;
                     else         i_rdata_d = mem_readdata;
                  end
               end else begin
                  // Requester gave up: finish the access silently.
                  state_d = IDLE;
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         gnt_d_q   <= 1'b0;
         write_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         gnt_d_q   <= gnt_d_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

`ifdef RR_ARB_EN
   // Round-robin pointer, reset to "instruction side served last".
   always_ff @(posedge clock or posedge reset) begin
      if (reset) last_d_q <= 1'b0;
      else       last_d_q <= last_d_d;
   end
`endif

   assign mem_read      = is_serve(state_q) & ~write_q;
   assign mem_write     = is_serve(state_q) &  write_q;
   assign mem_address   = addr_q;
   assign mem_writedata = wdata_q;

   assign i_readdata = i_rdata_q;
   assign d_readdata = d_rdata_q;

   // Stall whenever a request is up, except during that side's RESP cycle.
   assign i_busywait = w_i_req & ~((state_q == RESP) & ~gnt_d_q);
   assign d_busywait = w_d_req & ~((state_q == RESP) &  gnt_d_q);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter. Each scenario's cycle-by-
//            cycle expectations are derived from the service order and the
//            memory stall counts; a behavioural memory answers the strobes.
// Config   : RR_ARB_EN - selects the round-robin arbitration expectation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

   localparam int AW = 28;
   localparam int LW = 128;
   typedef logic [LW-1:0] line_t;

   logic          clock;
   logic          reset;
   logic          i_read;
   logic [AW-1:0] i_address;
   line_t         i_readdata;
   logic          i_busywait;
   logic          d_read;
   logic          d_write;
   logic [AW-1:0] d_address;
   line_t         d_writedata;
   line_t         d_readdata;
   logic          d_busywait;
   logic          mem_read;
   logic          mem_write;
   logic [AW-1:0] mem_address;
   line_t         mem_writedata;
   line_t         mem_readdata;
   logic          mem_busywait;

   int n_tests = 0;
   int n_fail  = 0;

   // model state
   line_t ref_mem [int];     // expected memory contents
   line_t mem_store [int];   // environment memory, written by the DUT
   line_t prev_i, prev_d;
   bit    last_d;
   int    stall_q[$];
   int    burst_cnt = 0;
   int    cur_stall = 0;

   mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
      .clock         (clock),
      .reset         (reset),
      .i_read        (i_read),
      .i_address     (i_address),
      .i_readdata    (i_readdata),
      .i_busywait    (i_busywait),
      .d_read        (d_read),
      .d_write       (d_write),
      .d_address     (d_address),
      .d_writedata   (d_writedata),
      .d_readdata    (d_readdata),
      .d_busywait    (d_busywait),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_address   (mem_address),
      .mem_writedata (mem_writedata),
      .mem_readdata  (mem_readdata),
      .mem_busywait  (mem_busywait)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input line_t got, input line_t exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic line_t init_line(input int a);
      return {4{32'h5EED_0000 ^ a}};
   endfunction

   function automatic line_t ref_line(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
   endfunction

   function automatic line_t store_line(input int a);
      return mem_store.exists(a) ? mem_store[a] : init_line(a);
   endfunction

   // Memory side: stall the next queued number of cycles per burst.
   task automatic drive_mem();
      if (mem_read || mem_write) begin
         if (burst_cnt == 0)
            cur_stall = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
         mem_busywait = (burst_cnt < cur_stall);
         mem_readdata = store_line(int'(mem_address));
         burst_cnt++;
      end else begin
         burst_cnt    = 0;
         mem_busywait = 1'b0;
      end
   endtask

   // One scenario: optional I read, optional D access raised at d_start.
   task automatic run_scn(input bit use_i, input bit use_d, input bit d_wr,
                          input bit d_both, input int d_start, input int ia,
                          input int da, input line_t dd, input int si, input int sd);
      bit    i_first;
      int    s1, s2;
      int    lo_i, hi_i, resp_i, lo_d, hi_d, resp_d, last_c;
      bit    in_i, in_d;
      line_t exp_i, exp_d;
      logic  e_mr, e_mw, e_ibw, e_dbw;

      if (use_i && use_d) begin
         if (d_start != 0) i_first = 1'b1;
         else begin
`ifdef RR_ARB_EN
            i_first = last_d;
`else
            i_first = 1'b0;
`endif
         end
      end else begin
         i_first = use_i;
      end
      s1 = i_first ? si : sd;
      s2 = i_first ? sd : si;
      stall_q.delete();
      stall_q.push_back(s1);
      if (use_i && use_d) stall_q.push_back(s2);

      // first access: strobes 1..1+s, RESP at 2+s; second follows after IDLE
      if (i_first) begin
         lo_i = 1; hi_i = 1 + si; resp_i = 2 + si;
         lo_d = 4 + si; hi_d = 4 + si + sd; resp_d = 5 + si + sd;
      end else begin
         lo_d = 1; hi_d = 1 + sd; resp_d = 2 + sd;
         lo_i = 4 + sd; hi_i = 4 + sd + si; resp_i = 5 + sd + si;
      end
      last_c = 0;
      if (use_i && resp_i + 1 > last_c) last_c = resp_i + 1;
      if (use_d && resp_d + 1 > last_c) last_c = resp_d + 1;

      exp_i = prev_i;
      exp_d = prev_d;
      if (i_first) begin
         exp_i = ref_line(ia);
         if (use_d) begin
            if (d_wr) ref_mem[da] = dd; else exp_d = ref_line(da);
         end
      end else begin
         if (use_d) begin
            if (d_wr) ref_mem[da] = dd; else exp_d = ref_line(da);
         end
         if (use_i) exp_i = ref_line(ia);
      end
      last_d = (use_i && use_d) ? i_first : use_d;

      for (int c = 0; c <= last_c; c++) begin
         @(posedge clock);
         #1;
         if (use_i && c == 0) begin
            i_read    = 1'b1;
            i_address = ia[AW-1:0];
         end
         if (use_d && c == d_start) begin
            d_address   = da[AW-1:0];
            d_writedata = dd;
            d_write     = d_wr;
            d_read      = !d_wr || d_both;
         end
         if (use_i && c == resp_i + 1) i_read = 1'b0;
         if (use_d && c == resp_d + 1) begin
            d_read  = 1'b0;
            d_write = 1'b0;
         end
         drive_mem();
         @(negedge clock);
         in_i  = use_i && c >= lo_i && c <= hi_i;
         in_d  = use_d && c >= lo_d && c <= hi_d;
         e_mr  = in_i || (in_d && !d_wr);
         e_mw  = in_d && d_wr;
         e_ibw = use_i && c < resp_i;
         e_dbw = use_d && c >= d_start && c < resp_d;
         check($sformatf("c%0d mem_read", c), mem_read, e_mr);
         check($sformatf("c%0d mem_write", c), mem_write, e_mw);
         check($sformatf("c%0d i_busywait", c), i_busywait, e_ibw);
         check($sformatf("c%0d d_busywait", c), d_busywait, e_dbw);
         check($sformatf("c%0d i_readdata", c), i_readdata,
               (use_i && c >= resp_i) ? exp_i : prev_i);
         check($sformatf("c%0d d_readdata", c), d_readdata,
               (use_d && !d_wr && c >= resp_d) ? exp_d : prev_d);
         if (in_i) check($sformatf("c%0d mem_address_i", c), mem_address, ia[AW-1:0]);
         if (in_d) check($sformatf("c%0d mem_address_d", c), mem_address, da[AW-1:0]);
         if (in_d && d_wr) check($sformatf("c%0d mem_writedata", c), mem_writedata, dd);
         if (mem_write && !mem_busywait) mem_store[int'(mem_address)] = mem_writedata;
      end
      prev_i = exp_i;
      prev_d = exp_d;
   endtask

   // Reset asserted while a data read is stalled in memory.
   task automatic reset_mid_serve();
      stall_q.delete();
      stall_q.push_back(8);
      @(posedge clock); #1;
      d_address = 28'h0000050;
      d_read    = 1'b1;
      drive_mem();
      @(posedge clock); #1;
      drive_mem();
      @(negedge clock);
      check("rst pre mem_read", mem_read, 1'b1);
      #1 reset = 1'b1;
      #1;
      check("rst mem_read", mem_read, 1'b0);
      check("rst mem_write", mem_write, 1'b0);
      check("rst mem_address", mem_address, '0);
      check("rst mem_writedata", mem_writedata, '0);
      check("rst i_readdata", i_readdata, '0);
      check("rst d_readdata", d_readdata, '0);
      check("rst d_busywait", d_busywait, 1'b1);
      @(posedge clock); #1;
      reset  = 1'b0;
      d_read = 1'b0;
      drive_mem();
      prev_i = '0;
      prev_d = '0;
      last_d = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         check($sformatf("post-rst c%0d mem_read", c), mem_read, 1'b0);
         check($sformatf("post-rst c%0d d_busywait", c), d_busywait, 1'b0);
         check($sformatf("post-rst c%0d d_readdata", c), d_readdata, '0);
         @(posedge clock); #1;
         drive_mem();
      end
   endtask

   initial begin
      int    kind, ia, da, si, sd, dst;
      bit    dwr, dboth;
      line_t dd;

      reset        = 1'b1;
      i_read       = 1'b0;
      i_address    = '0;
      d_read       = 1'b0;
      d_write      = 1'b0;
      d_address    = '0;
      d_writedata  = '0;
      mem_readdata = '0;
      mem_busywait = 1'b0;
      prev_i       = '0;
      prev_d       = '0;
      last_d       = 1'b0;

      @(posedge clock); #1;
      check("reset mem_read", mem_read, 1'b0);
      check("reset mem_write", mem_write, 1'b0);
      check("reset mem_address", mem_address, '0);
      check("reset mem_writedata", mem_writedata, '0);
      check("reset i_readdata", i_readdata, '0);
      check("reset d_readdata", d_readdata, '0);
      check("reset i_busywait", i_busywait, 1'b0);
      check("reset d_busywait", d_busywait, 1'b0);
      @(posedge clock); #1;
      reset = 1'b0;

      // instruction read, memory stalls so mem_read is high 3 cycles
      ref_mem[32'h10]   = {16{8'hA5}};
      mem_store[32'h10] = {16{8'hA5}};
      run_scn(1, 0, 0, 0, 0, 32'h10, 0, '0, 2, 0);
      // data write-back
      run_scn(0, 1, 1, 0, 0, 0, 32'h20, 128'h1234, 0, 1);
      // simultaneous reads, twice (pointer behaviour on the repeat)
      run_scn(1, 1, 0, 0, 0, 32'h30, 32'h40, '0, 1, 1);
      run_scn(1, 1, 0, 0, 0, 32'h30, 32'h40, '0, 0, 2);
      // data read arrives while the instruction read is in flight
      run_scn(1, 1, 0, 0, 1, 32'h60, 32'h70, '0, 3, 0);
      // read+write together is a write; then read it back
      run_scn(0, 1, 1, 1, 0, 0, 32'h80, {4{32'hCAFE_F00D}}, 1, 1);
      run_scn(1, 0, 0, 0, 0, 32'h80, 0, '0, 0, 0);

      reset_mid_serve();
      // after reset the pointer again favours the data side
      run_scn(1, 1, 0, 0, 0, 32'h90, 32'hA0, '0, 0, 0);

      for (int n = 0; n < 40; n++) begin
         kind  = $urandom_range(0, 3);
         ia    = 32'h100 + 16 * $urandom_range(0, 7);
         da    = 32'h100 + 16 * $urandom_range(0, 7);
         si    = $urandom_range(0, 3);
         sd    = $urandom_range(0, 3);
         dwr   = $urandom_range(0, 1);
         dboth = dwr && ($urandom_range(0, 1) == 1);
         dd    = {$urandom, $urandom, $urandom, $urandom};
         case (kind)
            0:       run_scn(1, 0, 0, 0, 0, ia, da, dd, si, sd);
            1:       run_scn(0, 1, dwr, dboth, 0, ia, da, dd, si, sd);
            2:       run_scn(1, 1, dwr, dboth, 0, ia, da, dd, si, sd);
            default: begin
               dst = $urandom_range(1, 1 + si);
               run_scn(1, 1, dwr, dboth, dst, ia, da, dd, si, sd);
            end
         endcase
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
